// File: rtl/load_store_unit.sv
// load_store_unit
// Data-memory access stage of the RV32I core. Turns the ALU result into a
// single word-aligned request over a req/ack handshake. Produces byte enables
// and lane-replicated store data, and returns extended load data to writeback.
// The PC is stalled while an access is pending.

module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] LSUaddr,
  input  logic [31:0] LSUwdata,
  input  logic [2:0]  LSUfunc3,
  input  logic        LSUload,
  input  logic        LSUstore,
  output logic [31:0] LSUrdata,
  output logic        LSUbusy,
  output logic        LSUdone,
  output logic        LSUfault,
  output logic [31:0] MEMaddr,
  output logic [31:0] MEMwdata,
  output logic [3:0]  MEMbe,
  output logic        MEMwe,
  output logic        MEMreq,
  input  logic        MEMack,
  input  logic [31:0] MEMrdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Access size encoding in func3[1:0]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg,  addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  be_reg,    be_next;
  logic        we_reg,    we_next;
  logic        req_reg,   req_next;
  logic [2:0]  kind_reg,  kind_next;
  logic [1:0]  lo_reg,    lo_next;
  logic        fault_reg, fault_next;
  logic [31:0] rdata_reg, rdata_next;

  // ---------------------------------------------------------------------
  // Start decode and fault classification (purely from the core's inputs)
  // ---------------------------------------------------------------------
  logic       start;
  logic [1:0] size;
  logic       bad_func3;
  logic       bad_store;
  logic       misaligned;
  logic       start_fault;

  assign start      = LSUload | LSUstore;
  assign size       = LSUfunc3[1:0];
  // 011, 110 and 111 have no meaning for loads or stores
  assign bad_func3  = (LSUfunc3 == 3'b011) | (LSUfunc3[2] & LSUfunc3[1]);
  // Unsigned variants exist only for loads
  assign bad_store  = LSUstore & LSUfunc3[2];
  assign misaligned = ((size == SZ_H) & LSUaddr[0]) |
                      ((size == SZ_W) & (LSUaddr[1:0] != 2'b00));
  assign start_fault = (LSUload & LSUstore) | bad_func3 | bad_store | misaligned;

  // ---------------------------------------------------------------------
  // Per-lane byte enables and store data replication
  // ---------------------------------------------------------------------
  logic [3:0]  be_dec;
  logic [31:0] wdata_dec;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);

      // A lane is enabled when it falls inside the accessed byte/half/word
      always_comb begin
        be_dec[gi] = 1'b0;
        case (size)
          SZ_B:    be_dec[gi] = (LSUaddr[1:0] == LANE);
          SZ_H:    be_dec[gi] = (LSUaddr[1] == LANE[1]);
          default: be_dec[gi] = 1'b1;
        endcase
      end

      // Replicate the low byte/half across all lanes so any enabled lane
      // sees the right data regardless of the offset
      always_comb begin
        wdata_dec[8*gi +: 8] = LSUwdata[8*gi +: 8];
        case (size)
          SZ_B:    wdata_dec[8*gi +: 8] = LSUwdata[7:0];
          SZ_H:    wdata_dec[8*gi +: 8] = LSUwdata[8*(gi % 2) +: 8];
          default: wdata_dec[8*gi +: 8] = LSUwdata[8*gi +: 8];
        endcase
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Load extraction from the returned word using the latched offset/kind
  // ---------------------------------------------------------------------
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign byte_sel = MEMrdata[{lo_reg, 3'b000} +: 8];
  assign half_sel = lo_reg[1] ? MEMrdata[31:16] : MEMrdata[15:0];

  // Sign- or zero-extend the selected lane according to the load kind
  always_comb begin
    load_ext = MEMrdata;
    case (kind_reg)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h000000, byte_sel};
      3'b101:  load_ext = {16'h0000, half_sel};
      default: load_ext = MEMrdata;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: next state and next values of every registered output
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    be_next    = be_reg;
    we_next    = we_reg;
    req_next   = req_reg;
    kind_next  = kind_reg;
    lo_next    = lo_reg;
    fault_next = fault_reg;
    rdata_next = rdata_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (start_fault) begin
            // Rejected access: no memory traffic, just report it
            fault_next = 1'b1;
            state_next = DONE;
          end else begin
            addr_next  = {LSUaddr[31:2], 2'b00};
            wdata_next = wdata_dec;
            be_next    = be_dec;
            we_next    = LSUstore;
            kind_next  = LSUfunc3;
            lo_next    = LSUaddr[1:0];
            fault_next = 1'b0;
            req_next   = 1'b1;
            state_next = REQ;
          end
        end
      end

      REQ: begin
        // MEM outputs stay frozen until the memory accepts
        if (MEMack) begin
          req_next   = 1'b0;
          state_next = DONE;
          if (!we_reg) begin
            rdata_next = load_ext;
          end
        end
      end

      DONE: begin
        // The core still holds its request here; it is not re-accepted
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      be_reg    <= 4'b0000;
      we_reg    <= 1'b0;
      req_reg   <= 1'b0;
      kind_reg  <= 3'b000;
      lo_reg    <= 2'b00;
      fault_reg <= 1'b0;
      rdata_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      be_reg    <= be_next;
      we_reg    <= we_next;
      req_reg   <= req_next;
      kind_reg  <= kind_next;
      lo_reg    <= lo_next;
      fault_reg <= fault_next;
      rdata_reg <= rdata_next;
    end
  end

  assign MEMaddr  = addr_reg;
  assign MEMwdata = wdata_reg;
  assign MEMbe    = be_reg;
  assign MEMwe    = we_reg;
  assign MEMreq   = req_reg;
  assign LSUrdata = rdata_reg;

  assign LSUdone  = (state_reg == DONE);
  assign LSUfault = (state_reg == DONE) & fault_reg;
  assign LSUbusy  = (state_reg == REQ) | ((state_reg == IDLE) & start);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: drives one instruction at a time,
// plays the memory side, and checks completions against a scoreboard.

module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic [31:0] LSUaddr;
  logic [31:0] LSUwdata;
  logic [2:0]  LSUfunc3;
  logic        LSUload;
  logic        LSUstore;
  logic [31:0] LSUrdata;
  logic        LSUbusy;
  logic        LSUdone;
  logic        LSUfault;
  logic [31:0] MEMaddr;
  logic [31:0] MEMwdata;
  logic [3:0]  MEMbe;
  logic        MEMwe;
  logic        MEMreq;
  logic        MEMack;
  logic [31:0] MEMrdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  load_store_unit dut (
    .clk      (clk),
    .rst      (rst),
    .LSUaddr  (LSUaddr),
    .LSUwdata (LSUwdata),
    .LSUfunc3 (LSUfunc3),
    .LSUload  (LSUload),
    .LSUstore (LSUstore),
    .LSUrdata (LSUrdata),
    .LSUbusy  (LSUbusy),
    .LSUdone  (LSUdone),
    .LSUfault (LSUfault),
    .MEMaddr  (MEMaddr),
    .MEMwdata (MEMwdata),
    .MEMbe    (MEMbe),
    .MEMwe    (MEMwe),
    .MEMreq   (MEMreq),
    .MEMack   (MEMack),
    .MEMrdata (MEMrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the completing access
  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s.sb: observed completion expected none", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".fault"}, 32'(LSUfault), 32'(e.fault));
      chk({tag, ".rdata"}, LSUrdata, e.rdata);
    end
  endtask

  // One complete instruction: start, optional memory phase, DONE, release
  task automatic run_access(
    input string       tag,
    input logic        ld,
    input logic        st,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] memword,
    input int          waits,
    input logic        exp_fault,
    input logic [31:0] exp_rdata,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wdata
  );
    exp_t e;
    e.fault = exp_fault;
    e.rdata = exp_rdata;
    sb.push_back(e);

    @(posedge clk); #1;
    LSUload  = ld;
    LSUstore = st;
    LSUfunc3 = f3;
    LSUaddr  = addr;
    LSUwdata = wdata;
    MEMrdata = memword;
    @(negedge clk);
    chk({tag, ".busyN"}, 32'(LSUbusy), 32'd1);
    chk({tag, ".reqN"},  32'(MEMreq),  32'd0);

    if (!exp_fault) begin
      for (int k = 0; k <= waits; k++) begin
        @(posedge clk); #1;
        MEMack = (k == waits);
        @(negedge clk);
        chk({tag, ".req"},  32'(MEMreq),  32'd1);
        chk({tag, ".busy"}, 32'(LSUbusy), 32'd1);
        chk({tag, ".done"}, 32'(LSUdone), 32'd0);
        chk({tag, ".addr"}, MEMaddr, {addr[31:2], 2'b00});
        chk({tag, ".be"},   32'(MEMbe),   32'(exp_be));
        chk({tag, ".we"},   32'(MEMwe),   32'(st));
        if (st) chk({tag, ".wdata"}, MEMwdata, exp_wdata);
      end
      @(posedge clk); #1;
      MEMack = 1'b0;
    end else begin
      @(posedge clk); #1;
    end

    // DONE cycle
    @(negedge clk);
    chk({tag, ".doneD"}, 32'(LSUdone), 32'd1);
    chk({tag, ".busyD"}, 32'(LSUbusy), 32'd0);
    chk({tag, ".reqD"},  32'(MEMreq),  32'd0);
    sb_check(tag);
    $display("txn %s: ld=%0b st=%0b f3=%b addr=%h fault=%0b rdata=%h",
             tag, ld, st, f3, addr, LSUfault, LSUrdata);

    // Core advances: request drops, unit must be back in IDLE
    @(posedge clk); #1;
    LSUload  = 1'b0;
    LSUstore = 1'b0;
    @(negedge clk);
    chk({tag, ".doneI"}, 32'(LSUdone), 32'd0);
    chk({tag, ".reqI"},  32'(MEMreq),  32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    LSUaddr  = 32'h0;
    LSUwdata = 32'h0;
    LSUfunc3 = 3'b000;
    LSUload  = 1'b0;
    LSUstore = 1'b0;
    MEMack   = 1'b0;
    MEMrdata = 32'h0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.rdata", LSUrdata, 32'h0);
    chk("rst.addr",  MEMaddr,  32'h0);
    chk("rst.wdata", MEMwdata, 32'h0);
    chk("rst.be",    32'(MEMbe),   32'h0);
    chk("rst.we",    32'(MEMwe),   32'h0);
    chk("rst.req",   32'(MEMreq),  32'h0);
    chk("rst.done",  32'(LSUdone), 32'h0);
    chk("rst.fault", 32'(LSUfault), 32'h0);
    chk("rst.busy",  32'(LSUbusy), 32'h0);
    $display("txn reset: outputs cleared");

    //          tag     ld    st    f3      addr          wdata         memword       w  flt   rdata         be       wdata
    run_access("LW",   1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0);
    run_access("LB",   1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'h0,        32'h80FF_0102, 0, 1'b0, 32'hFFFF_FF80, 4'b1000, 32'h0);
    run_access("LBU",  1'b1, 1'b0, 3'b100, 32'h0000_0013, 32'h0,        32'h80FF_0102, 0, 1'b0, 32'h0000_0080, 4'b1000, 32'h0);
    run_access("SH",   1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 32'h0,        3, 1'b0, 32'h0000_0080, 4'b1100, 32'hABCD_ABCD);
    run_access("LWmis",1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,         0, 1'b1, 32'h0000_0080, 4'b0000, 32'h0);
    run_access("F011", 1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         0, 1'b1, 32'h0000_0080, 4'b0000, 32'h0);
    run_access("LDST", 1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0,        32'h0,         0, 1'b1, 32'h0000_0080, 4'b0000, 32'h0);
    run_access("SBU",  1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,         0, 1'b1, 32'h0000_0080, 4'b0000, 32'h0);
    run_access("SB",   1'b0, 1'b1, 3'b000, 32'h0000_0041, 32'h0000_005A, 32'h0,        1, 1'b0, 32'h0000_0080, 4'b0010, 32'h5A5A_5A5A);
    run_access("LH",   1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_0000, 0, 1'b0, 32'hFFFF_8001, 4'b1100, 32'h0);
    run_access("LHU",  1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0,        32'hBEEF_1234, 0, 1'b0, 32'h0000_BEEF, 4'b1100, 32'h0);
    run_access("SW",   1'b0, 1'b1, 3'b010, 32'h0000_0004, 32'hCAFE_F00D, 32'h0,        0, 1'b0, 32'h0000_BEEF, 4'b1111, 32'hCAFE_F00D);

    // Reset while a load is waiting for its acknowledge
    @(posedge clk); #1;
    LSUload  = 1'b1;
    LSUfunc3 = 3'b010;
    LSUaddr  = 32'h0000_0030;
    MEMrdata = 32'h1111_2222;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort.req", 32'(MEMreq), 32'd1);
    @(posedge clk); #1;
    rst     = 1'b1;
    LSUload = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort.reqoff", 32'(MEMreq),  32'd0);
    chk("abort.busy",   32'(LSUbusy), 32'd0);
    chk("abort.done",   32'(LSUdone), 32'd0);
    chk("abort.addr",   MEMaddr,      32'h0);
    @(posedge clk); #1;
    MEMack = 1'b1;
    @(negedge clk);
    chk("abort.ackdone", 32'(LSUdone), 32'd0);
    @(posedge clk); #1;
    MEMack = 1'b0;
    @(negedge clk);
    chk("abort.latedone", 32'(LSUdone), 32'd0);
    chk("abort.rdata",    LSUrdata,     32'h0);
    chk("abort.sbempty",  32'(sb.size()), 32'd0);
    $display("txn abort: reset during REQ, req=%0b done=%0b", MEMreq, LSUdone);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential data-memory access stage for the single-cycle RV32I core, directly downstream of the ALU. It takes the ALU result as the effective address, issues one request to the data memory over a req/ack handshake, builds byte enables and aligned store data, and returns sign/zero-extended load data to writeback. While an access is in flight it stalls the PC.

## Interface
- No parameters. Address and data widths are fixed at 32 bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `LSUaddr` in 32: effective address, driven by the ALU result.
- `LSUwdata` in 32: store data (rs2).
- `LSUfunc3` in 3: access size and sign. 000 = B, 001 = H, 010 = W, 100 = BU (loads only), 101 = HU (loads only).
- `LSUload` in 1: load request level, held by the core for the whole instruction.
- `LSUstore` in 1: store request level, held by the core for the whole instruction.
- `LSUrdata` out 32: extended load result, held until the next successful load.
- `LSUbusy` out 1: PC stall, combinational.
- `LSUdone` out 1: one-cycle completion pulse.
- `LSUfault` out 1: one-cycle pulse, coincident with `LSUdone`, marking a rejected access.
- `MEMaddr` out 32: word-aligned address, with `addr[1:0]` forced to 00.
- `MEMwdata` out 32: lane-replicated store data.
- `MEMbe` out 4: byte enables.
- `MEMwe` out 1: 1 = write.
- `MEMreq` out 1: request, held until acknowledged.
- `MEMack` in 1: memory accept/response; `MEMrdata` is valid in the same cycle.
- `MEMrdata` in 32: memory read word.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: a start is `LSUload | LSUstore`. It is accepted only in IDLE.
  - Legal start: register `MEMaddr`, `MEMwdata`, `MEMbe`, `MEMwe` (= `LSUstore`), the load kind and `addr[1:0]`. Set `MEMreq` = 1 and go to REQ.
  - Faulting start: no memory request. Latch the fault and go to DONE.
- A start faults on any of:
  - `LSUload` and `LSUstore` both high.
  - `LSUfunc3` is 011, 110 or 111.
  - A store with `LSUfunc3` 100 or 101.
  - Halfword with `addr[0]` = 1.
  - Word with `addr[1:0]` ≠ 00.
- REQ: hold all MEM outputs stable.
  - While `MEMack` = 0, stay in REQ.
  - On `MEMack` = 1, drop `MEMreq` and go to DONE.
  - If the access is a load, capture the extended data into `LSUrdata` on that same edge.
- DONE: `LSUdone` = 1 for exactly one cycle. `LSUfault` = 1 in that cycle if the start faulted. Go to IDLE.
  - A start still held high during DONE is not re-accepted, because the core has not yet advanced.
- Byte enables and store data:
  - B: `MEMbe` = 0001 << `addr[1:0]`; `MEMwdata` = `{4{wdata[7:0]}}`.
  - H: `MEMbe` = 0011 when `addr[1]` = 0, 1100 when `addr[1]` = 1; `MEMwdata` = `{2{wdata[15:0]}}`.
  - W: `MEMbe` = 1111; `MEMwdata` = `wdata`.
  - Loads drive the same `MEMbe` pattern with `MEMwe` = 0.
- Load extraction: select the byte or halfword lane by the latched `addr[1:0]`.
  - B and H: sign-extend from bit 7 or bit 15.
  - BU and HU: zero-extend.
  - W: pass through.
- `LSUbusy` = (state == REQ) | (state == IDLE & start). It is 0 in DONE, so the PC advances at the end of the DONE cycle.
- `MEMack` is ignored outside REQ.
- A faulted access leaves `LSUrdata` unchanged. A store never changes `LSUrdata`.

## Timing
- Reset values: state IDLE; `LSUrdata`, `MEMaddr`, `MEMwdata` = 0; `MEMbe` = 0000; `MEMwe`, `MEMreq`, `LSUdone`, `LSUfault` = 0. `LSUbusy` = 0 unless a start is present.
- `rst` high at a rising edge aborts any access. The next cycle is IDLE with `MEMreq` = 0, and no `LSUdone` is issued for the aborted access.
- All MEM outputs are registered and never glitch during REQ.
- Latency with a zero-wait memory (start in cycle N):
  - `MEMreq` high in N+1, with `MEMack` = 1 in N+1.
  - `LSUdone` in N+2; `LSUbusy` high in N and N+1.
- Each memory wait cycle adds one cycle.
- Fault latency: start in N, `LSUdone` + `LSUfault` in N+1, `MEMreq` never rises.
- Back-to-back instructions: the next start is accepted at the earliest in N+3, the cycle after DONE.

## Test plan
- Reset, then LW with addr 0x0000_0010, memory word 0xDEAD_BEEF, zero-wait ack: `MEMaddr` = 0x10, `MEMbe` = 1111, `MEMwe` = 0, `LSUdone` at N+2, `LSUrdata` = 0xDEAD_BEEF.
- LB addr 0x13, memory word 0x80FF_0102: `MEMbe` = 1000, `LSUrdata` = 0xFFFF_FF80. Then LBU at the same address: `LSUrdata` = 0x0000_0080.
- SH addr 0x22, `wdata` 0x1234_ABCD, ack delayed 3 cycles:
  - `MEMaddr` = 0x20, `MEMbe` = 1100, `MEMwdata` = 0xABCD_ABCD, `MEMwe` = 1.
  - `MEMreq` held for 4 cycles, `LSUbusy` for 5 cycles, then `LSUdone`.
  - `LSUrdata` unchanged.
- Misaligned LW at addr 0x06: `MEMreq` stays 0; `LSUdone` and `LSUfault` both high in N+1. Repeat with func3 = 011 and with load+store both high: same response.
- Reset during REQ (ack withheld): the cycle after `rst`, `MEMreq` = 0 and state is IDLE; a later `MEMack` pulse produces no `LSUdone`.
- Consecutive LHU at 0x02 then SW at 0x04, each zero-wait: the second `MEMreq` rises no earlier than N+4. `LSUrdata` = upper half zero-extended, and the SW leaves it unchanged.
